// File: rtl/nx_dot_acc_int8.sv
// Signed dot-product engine: per-beat lane products, registered adder tree, and
// saturating per-frame accumulation with one result pulse per frame.
module nx_dot_acc_int8 #(
    parameter int LANES = 6,
    parameter int IW    = 8,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic [LANES*IW-1:0] in_a,
    input  logic [LANES*IW-1:0] in_b,
    output logic                out_valid,
    output logic [AW-1:0]       out_sum,
    output logic                out_ovf
);

    localparam int PW = 2 * IW;
    localparam int DW = PW + $clog2(LANES);

    logic signed [PW-1:0] prod_d [LANES];
    logic signed [PW-1:0] prod_q [LANES];
    logic                 v1_q, l1_q;
    logic signed [DW-1:0] tree_d, sum_q;
    logic                 v2_q, l2_q;
    logic signed [AW-1:0] acc_q, acc_d, acc_base;
    logic signed [AW:0]   tot;
    logic                 ovf_q, ovf_d, sat;
    logic                 open_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = PW'($signed(in_a[i*IW +: IW])) * PW'($signed(in_b[i*IW +: IW]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            l1_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            v1_q <= in_valid;
            l1_q <= in_valid & in_last;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    always_comb begin
        tree_d = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_d = tree_d + DW'(prod_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q  <= 1'b0;
            l2_q  <= 1'b0;
            sum_q <= '0;
        end else begin
            v2_q  <= v1_q;
            l2_q  <= l1_q;
            sum_q <= tree_d;
        end
    end

    // The first beat of a frame adds to zero rather than the previous frame's total.
    always_comb begin
        acc_base = open_q ? acc_q : '0;
        tot      = (AW+1)'(acc_base) + (AW+1)'(sum_q);
        acc_d    = tot[AW-1:0];
        sat      = 1'b0;
        if (tot[AW:AW-1] == 2'b01) begin
            acc_d = {1'b0, {(AW-1){1'b1}}};
            sat   = 1'b1;
        end else if (tot[AW:AW-1] == 2'b10) begin
            acc_d = {1'b1, {(AW-1){1'b0}}};
            sat   = 1'b1;
        end
        ovf_d = (open_q & ovf_q) | sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            open_q    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= v2_q & l2_q;
            if (v2_q) begin
                acc_q  <= acc_d;
                ovf_q  <= ovf_d;
                open_q <= ~l2_q;
                if (l2_q) begin
                    out_sum <= acc_d;
                    out_ovf <= ovf_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_nx_dot_acc_int8.sv
// Scoreboard bench: four DUT configurations share one stimulus stream; a frame-level
// arithmetic model queues expected results which a negedge monitor pops and checks.
module tb_nx_dot_acc_int8;

    typedef struct packed {
        logic [3:0][63:0] sum;
        logic [3:0]       ovf;
        logic [31:0]      cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [127:0] a_bus = '0;
    logic [127:0] b_bus = '0;

    logic        v1, v6, v16, v20;
    logic        o1, o6, o16, o20;
    logic [31:0] s1, s6, s16;
    logic [19:0] s20;

    logic [3:0]       got_v, got_o;
    logic [3:0][63:0] got_sum;

    logic signed [7:0] la [16];
    logic signed [7:0] lb [16];

    int     lanes_of [4] = '{1, 6, 16, 6};
    int     aw_of    [4] = '{32, 32, 32, 20};
    longint macc     [4];
    bit     mov      [4];
    bit     open_frm = 1'b0;
    exp_t   sb[$];
    longint hist6[$];
    longint last_sum [4];
    bit     last_ovf [4];
    int     pulses = 0;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nx_dot_acc_int8 #(.LANES(1), .IW(8), .AW(32)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .in_a(a_bus[7:0]), .in_b(b_bus[7:0]),
        .out_valid(v1), .out_sum(s1), .out_ovf(o1)
    );
    nx_dot_acc_int8 #(.LANES(6), .IW(8), .AW(32)) u_d6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .in_a(a_bus[47:0]), .in_b(b_bus[47:0]),
        .out_valid(v6), .out_sum(s6), .out_ovf(o6)
    );
    nx_dot_acc_int8 #(.LANES(16), .IW(8), .AW(32)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .in_a(a_bus[127:0]), .in_b(b_bus[127:0]),
        .out_valid(v16), .out_sum(s16), .out_ovf(o16)
    );
    nx_dot_acc_int8 #(.LANES(6), .IW(8), .AW(20)) u_d20 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .in_a(a_bus[47:0]), .in_b(b_bus[47:0]),
        .out_valid(v20), .out_sum(s20), .out_ovf(o20)
    );

    assign got_v      = {v20, v16, v6, v1};
    assign got_o      = {o20, o16, o6, o1};
    assign got_sum[0] = {{32{s1[31]}}, s1};
    assign got_sum[1] = {{32{s6[31]}}, s6};
    assign got_sum[2] = {{32{s16[31]}}, s16};
    assign got_sum[3] = {{44{s20[19]}}, s20};

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest queued frame on all four units.
    always @(negedge clk) begin
        if (rst_n && (got_v != 4'h0)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", longint'(got_v), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_all", longint'(got_v), 15);
                chk("latency", cyc, longint'(e.cyc));
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("sum_u%0d", k), longint'($signed(got_sum[k])),
                        longint'($signed(e.sum[k])));
                    chk($sformatf("ovf_u%0d", k), longint'(got_o[k]), longint'(e.ovf[k]));
                    last_sum[k] = longint'($signed(got_sum[k]));
                    last_ovf[k] = got_o[k];
                end
                hist6.push_back(longint'($signed(got_sum[1])));
                pulses++;
            end
        end
    end

    task automatic set_all(input int a, input int b);
        for (int i = 0; i < 16; i++) begin
            la[i] = 8'(a);
            lb[i] = 8'(b);
        end
    endtask

    // Drive one cycle; valid beats update the model and completed frames are queued.
    task automatic issue(input logic v, input logic l);
        exp_t   e;
        longint dot, t, mx, mn;
        bit     ov;
        @(posedge clk);
        #1;
        in_valid = v;
        in_last  = l;
        for (int i = 0; i < 16; i++) begin
            a_bus[i*8 +: 8] = la[i];
            b_bus[i*8 +: 8] = lb[i];
        end
        if (v) begin
            e = '0;
            for (int k = 0; k < 4; k++) begin
                dot = 0;
                for (int i = 0; i < lanes_of[k]; i++) dot += longint'(la[i]) * longint'(lb[i]);
                t  = (open_frm ? macc[k] : 0) + dot;
                ov = open_frm ? mov[k] : 1'b0;
                mx = (longint'(1) <<< (aw_of[k] - 1)) - 1;
                mn = -mx - 1;
                if (t > mx) begin
                    t  = mx;
                    ov = 1'b1;
                end else if (t < mn) begin
                    t  = mn;
                    ov = 1'b1;
                end
                macc[k]  = t;
                mov[k]   = ov;
                e.sum[k] = 64'(t);
                e.ovf[k] = ov;
            end
            e.cyc = 32'(cyc + 3);
            if (l) sb.push_back(e);
            open_frm = !l;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        chk({tag, "_valid"}, longint'(got_v), 0);
        chk({tag, "_ovf"}, longint'(got_o), 0);
        for (int k = 0; k < 4; k++) chk({tag, "_sum"}, longint'(got_sum[k]), 0);
        sb.delete();
        open_frm = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int p0, nb, mode, pa, pb;
        set_all(0, 0);
        repeat (2) @(posedge clk);
        do_reset("reset");

        // Single-beat frame, lanes a=1..N, b=1.
        for (int i = 0; i < 16; i++) begin
            la[i] = 8'(i + 1);
            lb[i] = 8'sd1;
        end
        p0 = pulses;
        issue(1'b1, 1'b1);
        idle(5);
        chk("t1_pulses", pulses - p0, 1);
        chk("t1_sum", last_sum[1], 21);
        chk("t1_ovf", longint'(last_ovf[1]), 0);

        // Most-negative operands over three beats.
        set_all(-128, -128);
        p0 = pulses;
        issue(1'b1, 1'b0);
        issue(1'b1, 1'b0);
        issue(1'b1, 1'b1);
        idle(5);
        chk("t2_pulses", pulses - p0, 1);
        chk("t2_sum", last_sum[1], 294912);

        // Back-to-back frames with no gap.
        p0 = pulses;
        set_all(2, 2);
        issue(1'b1, 1'b0);
        issue(1'b1, 1'b1);
        set_all(1, -1);
        issue(1'b1, 1'b1);
        idle(5);
        chk("t3_pulses", pulses - p0, 2);
        chk("t3_sum_a", hist6[hist6.size()-2], 48);
        chk("t3_sum_b", hist6[hist6.size()-1], -6);

        // Bubbles inside a frame, then in_last without in_valid.
        set_all(1, 1);
        p0 = pulses;
        issue(1'b1, 1'b0);
        issue(1'b0, 1'b0);
        issue(1'b1, 1'b0);
        issue(1'b0, 1'b1);
        issue(1'b0, 1'b0);
        issue(1'b1, 1'b1);
        idle(5);
        chk("t4_sum", last_sum[1], 18);
        p0 = pulses;
        issue(1'b0, 1'b1);
        issue(1'b0, 1'b0);
        issue(1'b0, 1'b1);
        idle(5);
        chk("t4_no_pulse", pulses - p0, 0);

        // Positive clamp on the 20-bit unit, then a clean frame.
        set_all(127, 127);
        for (int i = 0; i < 6; i++) issue(1'b1, i == 5);
        idle(5);
        chk("t5_sat_sum", last_sum[3], 524287);
        chk("t5_sat_ovf", longint'(last_ovf[3]), 1);
        set_all(1, 1);
        issue(1'b1, 1'b1);
        idle(5);
        chk("t5_next_sum", last_sum[3], 6);
        chk("t5_next_ovf", longint'(last_ovf[3]), 0);

        // Reset mid-frame discards the partial accumulation.
        set_all(50, 50);
        p0 = pulses;
        issue(1'b1, 1'b0);
        issue(1'b1, 1'b0);
        do_reset("t6_rst");
        set_all(3, 3);
        issue(1'b1, 1'b1);
        idle(5);
        chk("t6_pulses", pulses - p0, 1);
        chk("t6_sum", last_sum[1], 54);

        // Random frames with bubbles; some frames use extreme operands to force clamping.
        for (int f = 0; f < 10000; f++) begin
            mode = $urandom_range(0, 3);
            nb   = $urandom_range(1, (mode == 0) ? 8 : 4);
            pa   = $urandom_range(0, 1) ? 127 : -128;
            pb   = $urandom_range(0, 1) ? 127 : -128;
            for (int bi = 0; bi < nb; bi++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) issue(1'b0, 1'($urandom_range(0, 1)));
                end
                for (int i = 0; i < 16; i++) begin
                    if (mode == 0) begin
                        la[i] = 8'(pa);
                        lb[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(pb);
                    end else begin
                        la[i] = 8'($urandom);
                        lb[i] = 8'($urandom);
                    end
                end
                issue(1'b1, bi == nb - 1);
            end
        end
        idle(6);
        chk("queue_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
